// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DIGIT = 2;

  // Operand width must split into whole digits.
  function automatic bit digit_multiple_ok(input int unsigned width, input int unsigned digit);
    return (digit != 0) && ((width % digit) == 0);
  endfunction

  localparam bit DEF_SHAPE_OK = digit_multiple_ok(DEF_WIDTH, DEF_DIGIT);

  // Ceiling log2, never below 1 so a single-digit counter still has a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder, reused every cycle by the serial adder.
module digit_adder #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic c;

  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle A+B+CIN adder processing DIGIT bits per clock with start/busy/done handshake.
// Optional subtract mode (A + ~B + 1) is enabled by defining ADDSUB_MODE_EN.
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned NDIG     = WIDTH / DIGIT;
  localparam int unsigned IDXW     = clog2(NDIG);
  localparam bit          SHAPE_OK = digit_multiple_ok(WIDTH, DIGIT);

  if (!SHAPE_OK) begin : g_bad_shape
    $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              busy_d, done_d, cout_d;
  logic [WIDTH-1:0]  sum_d;

  logic [WIDTH-1:0]  b_cap;
  logic              carry_cap;
  logic [DIGIT-1:0]  dsum;
  logic              dco;

  // Operand conditioning at capture: subtraction folds into B inversion and a forced carry.
`ifdef ADDSUB_MODE_EN
  assign b_cap     = sub ? ~b : b;
  assign carry_cap = sub ? 1'b1 : cin;
`else
  assign b_cap     = b;
  assign carry_cap = cin;
`endif

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x  (a_q[DIGIT-1:0]),
    .y  (b_q[DIGIT-1:0]),
    .ci (carry_q),
    .s  (dsum),
    .co (dco)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      sum     <= sum_d;
      cout    <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    sum_d   = sum;
    cout_d  = cout;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b_cap;
          carry_d = carry_cap;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        busy_d  = 1'b1;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        // New digit enters at the MSB; after NDIG steps the first digit lands at bit 0.
        sum_d   = WIDTH'({dsum, sum} >> DIGIT);
        carry_d = dco;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NDIG - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = dco;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed handshake cases plus randomized operands.
// Define ADDSUB_MODE_EN to also exercise subtract mode.
module tb_digit_serial_adder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DIGIT = 2;
  localparam int unsigned NDIG  = WIDTH / DIGIT;
  localparam int          LIMIT = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             sub;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int vectors   = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef ADDSUB_MODE_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: full-width unsigned result, bit WIDTH is the carry out.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic c, input logic s);
    logic [WIDTH:0] r;
`ifdef ADDSUB_MODE_EN
    if (s) r = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
    else   r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
`else
    r = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
    if (s) r = r;
`endif
    return r;
  endfunction

  task automatic drive_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                             input logic c, input logic s);
    @(negedge clk);
    start = 1'b1; a = x; b = y; cin = c; sub = s;
  endtask

  // Count edges after the accepting edge until done; bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                              input logic c, input logic s, input int n);
    logic [WIDTH:0] exp;
    exp = model(x, y, c, s);
    check({tag, "_latency"}, 32'(n), 32'(NDIG));
    check({tag, "_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(exp[WIDTH]));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  // Full single operation with done-pulse and hold checks.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic s);
    int n;
    logic [WIDTH-1:0] held;
    drive_start(x, y, c, s);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; cin = $urandom; sub = $urandom;
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    wait_done(n);
    check_result(tag, x, y, c, s, n);
    held = model(x, y, c, s) >> 0;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_sum_held"}, 32'(sum), 32'(held));
  endtask

  initial begin
    int n, pulses;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sum",  32'(sum),  32'd0);
    check("reset_cout", 32'(cout), 32'd0);
    @(negedge clk); rst = 1'b0;

    do_op("t1", 8'h01, 8'h01, 1'b0, 1'b0);
    do_op("t2", 8'hFF, 8'h01, 1'b0, 1'b0);
    do_op("t3", 8'hB5, 8'h93, 1'b1, 1'b0);

    // Start pulsed mid-run with different operands must be ignored.
    drive_start(8'h3C, 8'h47, 1'b1, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check_result("t4", 8'h3C, 8'h47, 1'b1, 1'b0, n);
    @(posedge clk); #1;
    check("t4_no_restart", 32'(busy), 32'd0);

    // Reset mid-run aborts with no done.
    drive_start(8'h77, 8'h88, 1'b1, 1'b0);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum",  32'(sum),  32'd0);
    check("t5_cout", 32'(cout), 32'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    check("t5_no_done", 32'(pulses), 32'd0);
    do_op("t5_after", 8'h12, 8'h34, 1'b0, 1'b0);

    // Back-to-back: start held into the DONE cycle with new operands.
    drive_start(8'h0F, 8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    wait_done(n);
    check_result("t6a", 8'h0F, 8'h01, 1'b0, 1'b0, n);
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("t6_done_drop", 32'(done), 32'd0);
    check("t6_busy_rise", 32'(busy), 32'd1);
    wait_done(n);
    check_result("t6b", 8'h10, 8'h20, 1'b0, 1'b0, n);
    check("t6b_sum_30", 32'(sum), 32'h30);
    @(posedge clk); #1;

`ifdef ADDSUB_MODE_EN
    do_op("t7a", 8'h05, 8'h09, 1'b1, 1'b1);
    check("t7a_sum_fc", 32'(sum), 32'hFC);
    do_op("t7b", 8'h09, 8'h05, 1'b0, 1'b1);
    check("t7b_cout", 32'(cout), 32'd1);
`endif

    // Randomized operations with random idle gaps.
    for (int k = 0; k < LIMIT; k++) begin
      logic [WIDTH-1:0] rx, ry;
      logic rc, rs;
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      rc = 1'($urandom);
`ifdef ADDSUB_MODE_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op("rnd", rx, ry, rc, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
